// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and helpers for the memory access unit.
//               Holds the sequencer state encoding, the access-size codes
//               and the lane extract / merge functions used by the
//               sub-word datapath. Sub-word support is controlled by the
//               MEM_ACCESS_SUBWORD_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Pull the addressed byte/half out of a memory word and extend it.
  // A half access is always half-aligned, so offs*8 selects the half lane.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offs,
                                               input logic        sign_ext);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {offs, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{sign_ext & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{sign_ext & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of a memory word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offs);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {offs, 3'b000};
    data = wdata << {offs, 3'b000};
    return (word & ~mask) | (data & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane alignment for sub-word accesses.
//               ld_data : addressed byte/half of rd_word, zero/sign extended
//               st_word : rd_word with st_data merged into the addressed lane
//               Only built when MEM_ACCESS_SUBWORD_EN is defined.
// Ports       : rd_word  (in 32)  word captured from memory
//               st_data  (in 32)  right-aligned store data
//               size     (in 2)   access size code
//               offs     (in 2)   byte offset within the word
//               sign_ext (in 1)   sign-extend sub-word loads
//               ld_data  (out 32) extended load result
//               st_word  (out 32) merged store word
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef MEM_ACCESS_SUBWORD_EN
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic        sign_ext,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  assign ld_data = lane_extract(rd_word, size, offs, sign_ext);
  assign st_word = lane_merge(rd_word, st_data, size, offs);

endmodule
`endif
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Initiator-side load/store sequencer for the unified memory.
//               Accepts one request at a time (valid/ready), drives the
//               memory strobe pins, captures read data after MEM_LAT edges
//               and returns a held response. Sub-word loads/stores (with
//               read-modify-write) exist only when MEM_ACCESS_SUBWORD_EN
//               is defined; otherwise byte/half requests return an error.
// Ports       : clk, rst_n                      clock, async active-low reset
//               req_valid/req_ready             request handshake
//               req_write/size/signed/addr/wdata request fields
//               resp_valid/resp_ready           response handshake
//               resp_rdata/resp_err             response payload
//               Op2En/Op2Rw/ReadWriteAddr/DataWrite memory command pins
//               Data                            memory read word
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              Op2En,
  output logic              Op2Rw,
  output logic [31:0]       ReadWriteAddr,
  output logic [31:0]       DataWrite,
  input  logic [31:0]       Data
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        op2en_q, op2en_d;
  logic        op2rw_q, op2rw_d;
  logic [31:0] rwaddr_q, rwaddr_d;
  logic [31:0] dwrite_q, dwrite_d;

  logic [31:0] req_word_idx;
  logic        acc_err;

  assign req_word_idx = 32'(req_addr >> 2);

`ifdef MEM_ACCESS_SUBWORD_EN
  // Request fields kept for the second half of a load or an RMW store.
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  offs_q, offs_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] lane_rdata;
  logic [31:0] lane_wdata;

  mem_lane_align u_lane_align (
    .rd_word  (Data),
    .st_data  (wdata_q),
    .size     (size_q),
    .offs     (offs_q),
    .sign_ext (signed_q),
    .ld_data  (lane_rdata),
    .st_word  (lane_wdata)
  );
`else
  // Without sub-word support only word accesses exist, so sign is moot.
  logic unused_signed;
  assign unused_signed = req_signed;
`endif

  always_comb begin
    acc_err = 1'b1;
    case (req_size)
      SZ_WORD: acc_err = (req_addr[1:0] != 2'b00);
`ifdef MEM_ACCESS_SUBWORD_EN
      SZ_HALF: acc_err = req_addr[0];
      SZ_BYTE: acc_err = 1'b0;
`endif
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    // Memory pins are single-cycle pulses and read 0 when not strobed.
    op2en_d      = 1'b0;
    op2rw_d      = 1'b0;
    rwaddr_d     = '0;
    dwrite_d     = '0;
`ifdef MEM_ACCESS_SUBWORD_EN
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    offs_d       = offs_q;
    wdata_d      = wdata_q;
    word_idx_d   = word_idx_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef MEM_ACCESS_SUBWORD_EN
          write_d    = req_write;
          size_d     = req_size;
          signed_d   = req_signed;
          offs_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          word_idx_d = req_word_idx;
`endif
          if (acc_err) begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d  = ST_WR;
            op2en_d  = 1'b1;
            op2rw_d  = 1'b1;
            rwaddr_d = req_word_idx;
            dwrite_d = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a word read.
            state_d  = ST_RD;
            op2en_d  = 1'b1;
            rwaddr_d = req_word_idx;
          end
        end
      end

      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
`ifdef MEM_ACCESS_SUBWORD_EN
          if (write_q) begin
            state_d  = ST_WR;
            op2en_d  = 1'b1;
            op2rw_d  = 1'b1;
            rwaddr_d = word_idx_q;
            dwrite_d = lane_wdata;
          end else begin
            state_d      = ST_RESP;
            resp_rdata_d = lane_rdata;
            resp_err_d   = 1'b0;
          end
`else
          state_d      = ST_RESP;
          resp_rdata_d = Data;
          resp_err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_WR: begin
        state_d      = ST_RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs follow the next state so they are registered.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      op2en_q      <= 1'b0;
      op2rw_q      <= 1'b0;
      rwaddr_q     <= '0;
      dwrite_q     <= '0;
`ifdef MEM_ACCESS_SUBWORD_EN
      write_q      <= 1'b0;
      size_q       <= SZ_WORD;
      signed_q     <= 1'b0;
      offs_q       <= '0;
      wdata_q      <= '0;
      word_idx_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      op2en_q      <= op2en_d;
      op2rw_q      <= op2rw_d;
      rwaddr_q     <= rwaddr_d;
      dwrite_q     <= dwrite_d;
`ifdef MEM_ACCESS_SUBWORD_EN
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      offs_q       <= offs_d;
      wdata_q      <= wdata_d;
      word_idx_q   <= word_idx_d;
`endif
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign Op2En         = op2en_q;
  assign Op2Rw         = op2rw_q;
  assign ReadWriteAddr = rwaddr_q;
  assign DataWrite     = dwrite_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. A synchronous RAM
//               model with MEM_LAT read latency serves the DUT; a reference
//               memory image updated at transaction level predicts load
//               results, write contents, error status and latency.
//               Honours MEM_ACCESS_SUBWORD_EN for the expected behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int LAT = 2;
`ifdef MEM_ACCESS_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        Op2En, Op2Rw;
  logic [31:0] ReadWriteAddr, DataWrite, Data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LAT(LAT), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .Op2En         (Op2En),
    .Op2Rw         (Op2Rw),
    .ReadWriteAddr (ReadWriteAddr),
    .DataWrite     (DataWrite),
    .Data          (Data)
  );

  // ---------------- memory model seen by the DUT ----------------
  logic [31:0] ref_mem [16];   // transaction-level reference image
  logic [31:0] ram     [16];   // what the DUT actually reads/writes
  logic [31:0] pipe    [LAT];
  logic        mem_init;
  int          rd_cnt = 0, wr_cnt = 0, idle_viol = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= ref_mem[i];
    end else if (Op2En && Op2Rw) begin
      ram[ReadWriteAddr[3:0]] <= DataWrite;
    end
    // Junk on the bus when no read is in flight; the DUT must ignore it.
    if (Op2En && !Op2Rw) pipe[0] <= ram[ReadWriteAddr[3:0]];
    else                 pipe[0] <= $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (Op2En && !Op2Rw) begin rd_cnt <= rd_cnt + 1; last_rd_addr <= ReadWriteAddr; end
    if (Op2En &&  Op2Rw) begin
      wr_cnt <= wr_cnt + 1; last_wr_addr <= ReadWriteAddr; last_wr_data <= DataWrite;
    end
  end
  assign Data = pipe[LAT-1];

  always @(negedge clk)
    if (!Op2En && (Op2Rw || ReadWriteAddr != 0 || DataWrite != 0)) idle_viol <= idle_viol + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction against the reference model.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic        e;
    logic [31:0] er;
    logic [7:0]  bv;
    logic [15:0] hv;
    int idx, off, elat, erd, ewr, rd0, wr0, lat, viol;
    logic [31:0] snap_d;
    logic        snap_e;
    idx = int'(addr[5:2]);
    off = int'(addr[1:0]);
    e = (sz == 2'd3) || (sz == 2'd2 && addr[1:0] != 2'b00) ||
        (sz == 2'd1 && (addr[0] || !SUB)) || (sz == 2'd0 && !SUB);
    er = 0; erd = 0; ewr = 0;
    if (e)                          elat = 1;
    else if (wr && sz == 2'd2)      begin elat = 2;       ewr = 1; end
    else if (wr)                    begin elat = 3 + LAT; erd = 1; ewr = 1; end
    else                            begin elat = 2 + LAT; erd = 1; end
    if (!e && !wr) begin
      bv = ref_mem[idx][8*off +: 8];
      hv = ref_mem[idx][8*(off & 2) +: 16];
      case (sz)
        2'd0:    er = sg ? {{24{bv[7]}}, bv} : {24'd0, bv};
        2'd1:    er = sg ? {{16{hv[15]}}, hv} : {16'd0, hv};
        default: er = ref_mem[idx];
      endcase
    end
    if (!e && wr) begin
      case (sz)
        2'd0:    ref_mem[idx][8*off +: 8] = wd[7:0];
        2'd1:    ref_mem[idx][8*(off & 2) +: 16] = wd[15:0];
        default: ref_mem[idx] = wd;
      endcase
    end

    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);                 // accept edge E0
    lat = 1;
    @(negedge clk);
    req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", lat, elat);
    check("resp_err", {31'd0, resp_err}, {31'd0, e});
    check("resp_rdata", resp_rdata, er);
    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
    viol = 0; snap_d = resp_rdata; snap_e = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      if (!resp_valid || req_ready || resp_rdata !== snap_d || resp_err !== snap_e) viol++;
    end
    if (hold > 0) check("resp_hold", viol, 0);
    resp_ready = 1;
    @(posedge clk); @(negedge clk);
    resp_ready = 0;
    check("valid_after_hs", {31'd0, resp_valid}, 32'd0);
    check("ready_after_hs", {31'd0, req_ready}, 32'd1);
    check("n_reads", rd_cnt - rd0, erd);
    check("n_writes", wr_cnt - wr0, ewr);
    if (erd != 0) check("rd_addr", last_rd_addr, idx);
    if (ewr != 0) begin
      check("wr_addr", last_wr_addr, idx);
      check("wr_data", last_wr_data, ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] a;
    int wr0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h0000_002A;
    ref_mem[1] = 32'h1122_3344;
    rst_n = 0; mem_init = 1;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_op2en", {31'd0, Op2En}, 32'd0);
    mem_init = 0; rst_n = 1;

    // Directed cases from the block's test plan.
    do_req(0, 2'd2, 0, 32'h0,  32'h0, 0);           // word load -> 0x2A
    check("tp_word0", ref_mem[0], 32'h0000_002A);
    do_req(1, 2'd2, 0, 32'h8,  32'hDEAD_BEEF, 0);   // word store
    do_req(0, 2'd2, 0, 32'h6,  32'h0, 0);           // misaligned word load
    do_req(1, 2'd0, 0, 32'h5,  32'h0000_007F, 0);   // byte store RMW
    do_req(0, 2'd0, 1, 32'h7,  32'h0, 0);           // signed byte load 0x11
    do_req(1, 2'd0, 0, 32'hC,  32'h0000_0083, 0);
    do_req(0, 2'd0, 1, 32'hC,  32'h0, 0);           // signed byte 0x83
    do_req(0, 2'd1, 1, 32'h6,  32'h0, 1);           // half load lane 1
    do_req(1, 2'd1, 0, 32'h3,  32'h1234, 0);        // misaligned half
    do_req(0, 2'd3, 0, 32'h0,  32'h0, 0);           // reserved size
    do_req(0, 2'd2, 0, 32'h8,  32'h0, 5);           // held response

    for (int t = 0; t < 80; t++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 3));
    end

    // Reset while the read of a request is outstanding (RMW when available).
    @(negedge clk);
    req_valid = 1; req_write = SUB; req_size = SUB ? 2'd0 : 2'd2; req_signed = 0;
    req_addr = SUB ? 32'h9 : 32'h10; req_wdata = 32'h55;
    @(posedge clk); @(negedge clk); req_valid = 0;
    @(posedge clk); @(negedge clk);               // now in WAIT
    wr0 = wr_cnt;
    rst_n = 0;
    #1;
    check("mid_rst_outputs", {Op2En, Op2Rw, resp_valid, resp_err}, 32'd0);
    check("mid_rst_addr_data", ReadWriteAddr | DataWrite | resp_rdata, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    check("post_rst_no_write", wr_cnt - wr0, 0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_mem", ram[SUB ? 2 : 4], ref_mem[SUB ? 2 : 4]);
    do_req(0, 2'd2, 0, 32'h4, 32'h0, 0);          // recovers normally

    check("idle_pins_zero", idle_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
